// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing the write port of an async FIFO among N_REQ
// requesters, all in the FIFO write-clock domain. One requester at a time
// owns the port for a bounded burst of beats. Its beats are forwarded as
// write_en/wdata. The arbiter stalls while the FIFO is full. It gives up the
// port on the owner's last beat, when the burst length reaches MAX_BURST, or
// when the owner has nothing to send (valid low while not full). Every grant
// is followed by one IDLE cycle before the next grant.
//
// Parameters
//   N_REQ      number of requesters (>= 2)
//   WIDTH      data width, equal to the FIFO data width
//   MAX_BURST  maximum beats per grant (>= 1)
//
// Ports
//   clk        in   1            FIFO write clock
//   rstn       in   1            asynchronous active-low reset
//   req_valid  in   N_REQ        per-requester beat valid
//   req_last   in   N_REQ        per-requester end-of-packet (qualified by valid)
//   req_data   in   N_REQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  N_REQ        beat accepted when valid & ready
//   full       in   1            FIFO full flag (write-domain synchronized)
//   write_en   out  1            FIFO write strobe
//   wdata      out  WIDTH        FIFO write data (zero when no grant is held)
//   grant      out  N_REQ        one-hot current owner, zero when idle
//   busy       out  1            high while a grant is held (BURST state)
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   full,
    output logic                   write_en,
    output logic [WIDTH-1:0]       wdata,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    // (base + k) mod N_REQ, for k in [0, N_REQ]
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int               k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return PTR_W'(s);
    endfunction

    // Registered state
    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;

    // Next-state values
    state_t             w_state_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [PTR_W-1:0]   w_rr_ptr_nxt;
    logic [CNT_W-1:0]   w_beat_cnt_nxt;

    // Arbitration and burst bookkeeping
    logic               w_found;
    logic [PTR_W-1:0]   w_pick;
    logic [N_REQ-1:0]   w_pick_oh;
    logic               w_own_valid;
    logic               w_own_last;
    logic               w_in_burst;
    logic               w_beat;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cap_hit;
    logic               w_release;

    // Round-robin search: first valid requester at or above r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_rr_ptr, k);
            end
        end
        w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
    end

    assign w_in_burst  = (r_state == S_BURST);
    assign w_own_valid = req_valid[r_owner];
    assign w_own_last  = req_last[r_owner];
    assign w_beat      = w_in_burst & w_own_valid & !full;
    assign w_cnt_inc   = r_beat_cnt + 1'b1;
    assign w_cap_hit   = (w_cnt_inc == CNT_W'(MAX_BURST));

    // While full nothing is released: the owner may be waiting on space, not idle.
    // With full low, either there is no beat (owner idle -> release) or there is
    // a beat, which releases when it is the last one or fills the burst.
    assign w_release = w_in_burst & !full & (!w_own_valid | w_own_last | w_cap_hit);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Next-state and outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;

        busy      = 1'b0;
        write_en  = 1'b0;
        req_ready = '0;
        wdata     = '0;
        grant     = r_grant;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_BURST;
                    w_grant_nxt    = w_pick_oh;
                    w_owner_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                end
            end

            S_BURST: begin
                busy      = 1'b1;
                write_en  = w_beat;
                req_ready = r_grant & {N_REQ{!full}};
                wdata     = req_data[int'(r_owner)*WIDTH +: WIDTH];

                if (w_beat) begin
                    w_beat_cnt_nxt = w_cnt_inc;
                end
                if (w_release) begin
                    w_state_nxt    = S_IDLE;
                    w_grant_nxt    = '0;
                    w_rr_ptr_nxt   = wrap_add(r_owner, 1);
                    w_beat_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Bench for fifo_write_arbiter (N_REQ=4, WIDTH=32, MAX_BURST=4). Requester
// beats are loaded into per-requester stores. Loading a beat also pushes the
// expected FIFO write (owner grant, data) to a scoreboard, in the order the
// arbiter should emit them. A negedge monitor pops the scoreboard on every
// write_en. Directed per-cycle grant/write_en checks cover arbitration timing.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 16;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   full;
    logic                   write_en;
    logic [WIDTH-1:0]       wdata;
    logic [N_REQ-1:0]       grant;
    logic                   busy;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .N_REQ    (N_REQ),
        .WIDTH    (WIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_last (req_last),
        .req_data (req_data),
        .req_ready(req_ready),
        .full     (full),
        .write_en (write_en),
        .wdata    (wdata),
        .grant    (grant),
        .busy     (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Requester beat stores: {last, data}
    logic [WIDTH:0]         rmem [N_REQ][DEPTH];
    int                     rhead [N_REQ];
    int                     rtail [N_REQ];
    logic [N_REQ-1:0]       acc;

    // Expected FIFO writes: {grant, data}
    logic [N_REQ+WIDTH-1:0] sb [$];

    // Cycle tables (index 0 = first cycle after valid is sampled)
    bit         cap_g [14] = '{1,1,1,1,0,1,1,1,1,0,1,1,1,0};
    bit         cap_w [14] = '{1,1,1,1,0,1,1,1,1,0,1,1,0,0};
    logic [3:0] rr_g  [12] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                               4'b0100, 4'b0000, 4'b1000, 4'b0000,
                               4'b0001, 4'b0000, 4'b0010, 4'b0000};

    task automatic push_beat(input int i, input logic [WIDTH-1:0] d, input logic l);
        logic [N_REQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        rmem[i][rtail[i]] = {l, d};
        rtail[i]++;
        sb.push_back({oh, d});
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            if (acc[i]) rhead[i]++;
            if (rhead[i] < rtail[i]) begin
                req_valid[i] = 1'b1;
                {req_last[i], req_data[i*WIDTH +: WIDTH]} = rmem[i][rhead[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*WIDTH +: WIDTH] = '0;
            end
        end
        acc = '0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        acc       = '0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_reqs();
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_cyc(input string tag, input logic [N_REQ-1:0] g, input logic we);
        chk({tag, "_grant"}, grant, g);
        chk({tag, "_we"}, write_en, we);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        full = 1'b0;
        clear_reqs();
        sb.delete();
        step();
        step();
        rstn = 1'b1;
    endtask

    // Monitor: acceptance capture for the requester model and scoreboard compare
    always @(negedge clk) begin
        acc = req_valid & req_ready;
        if (write_en) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", 64'(wdata), 64'h0);
            end else begin
                logic [N_REQ+WIDTH-1:0] e;
                e = sb.pop_front();
                chk("wr_data", wdata, e[WIDTH-1:0]);
                chk("wr_grant", grant, e[N_REQ+WIDTH-1:WIDTH]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b1;
        full = 1'b0;
        clear_reqs();
        #1 rstn = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", write_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wdata", wdata, 0);
        apply_reset();

        // Single packet from req2, then rr_ptr=3 picks req3 over req0
        push_beat(2, 32'hA0, 1'b0);
        push_beat(2, 32'hA1, 1'b0);
        push_beat(2, 32'hA2, 1'b1);
        step(); settle(); chk_cyc("sp_c0", 4'b0000, 0); chk("sp_c0_ready", req_ready, 0);
        step(); settle(); chk_cyc("sp_c1", 4'b0100, 1); chk("sp_c1_busy", busy, 1);
        chk("sp_c1_ready", req_ready, 4'b0100);
        step(); settle(); chk_cyc("sp_c2", 4'b0100, 1);
        step(); settle(); chk_cyc("sp_c3", 4'b0100, 1);
        step(); settle(); chk_cyc("sp_c4", 4'b0000, 0);
        chk("sp_c4_busy", busy, 0);
        chk("sp_c4_wdata", wdata, 0);
        push_beat(3, 32'hB3, 1'b1);
        push_beat(0, 32'hB0, 1'b1);
        step(); settle(); chk_cyc("sp_rr_idle", 4'b0000, 0);
        step(); settle(); chk_cyc("sp_rr_g3", 4'b1000, 1);
        step(); settle(); chk_cyc("sp_rr_bubble", 4'b0000, 0);
        step(); settle(); chk_cyc("sp_rr_g0", 4'b0001, 1);
        step(); settle(); chk_cyc("sp_rr_end", 4'b0000, 0);
        chk("sp_sb_drained", sb.size(), 0);

        // Burst cap: req1 streams 10 beats without last
        apply_reset();
        for (int k = 0; k < 10; k++) push_beat(1, 32'h100 + k, 1'b0);
        step();
        for (int c = 0; c < 14; c++) begin
            step(); settle();
            chk_cyc($sformatf("cap_c%0d", c + 1), cap_g[c] ? 4'b0010 : 4'b0000, cap_w[c]);
        end
        chk("cap_sb_drained", sb.size(), 0);

        // Round-robin with all requesters valid, every beat last
        apply_reset();
        push_beat(0, 32'hC0, 1'b1);
        push_beat(1, 32'hC1, 1'b1);
        push_beat(2, 32'hC2, 1'b1);
        push_beat(3, 32'hC3, 1'b1);
        push_beat(0, 32'hC4, 1'b1);
        push_beat(1, 32'hC5, 1'b1);
        step();
        for (int c = 0; c < 12; c++) begin
            step(); settle();
            chk_cyc($sformatf("rr_c%0d", c + 1), rr_g[c], rr_g[c] != 4'b0000);
        end
        chk("rr_sb_drained", sb.size(), 0);

        // Backpressure: full for 5 cycles after the first beat of req3
        apply_reset();
        for (int k = 0; k < 4; k++) push_beat(3, 32'hD0 + k, 1'b0);
        step();
        step(); settle(); chk_cyc("bp_c1", 4'b1000, 1);
        for (int k = 0; k < 5; k++) begin
            step(); full = 1'b1; settle();
            chk_cyc($sformatf("bp_full%0d", k), 4'b1000, 0);
            chk($sformatf("bp_full%0d_ready", k), req_ready, 0);
        end
        step(); full = 1'b0; settle(); chk_cyc("bp_resume1", 4'b1000, 1);
        chk("bp_resume_ready", req_ready, 4'b1000);
        step(); settle(); chk_cyc("bp_resume2", 4'b1000, 1);
        step(); settle(); chk_cyc("bp_resume3", 4'b1000, 1);
        step(); settle(); chk_cyc("bp_release", 4'b0000, 0);
        chk("bp_sb_drained", sb.size(), 0);

        // Valid drop: req0 sends one beat then goes idle; req1 pending
        apply_reset();
        push_beat(0, 32'hE0, 1'b0);
        push_beat(1, 32'hE1, 1'b1);
        step();
        step(); settle(); chk_cyc("vd_c1", 4'b0001, 1);
        step(); settle(); chk_cyc("vd_c2", 4'b0001, 0);
        step(); settle(); chk_cyc("vd_c3", 4'b0000, 0);
        step(); settle(); chk_cyc("vd_c4", 4'b0010, 1);
        step(); settle(); chk_cyc("vd_c5", 4'b0000, 0);
        chk("vd_sb_drained", sb.size(), 0);

        // Reset mid-burst: req0 has sent 2 of 4 beats
        apply_reset();
        for (int k = 0; k < 4; k++) push_beat(0, 32'hF0 + k, 1'b0);
        step();
        step(); settle(); chk_cyc("rm_c1", 4'b0001, 1);
        step(); settle(); chk_cyc("rm_c2", 4'b0001, 1);
        step();
        #1 rstn = 1'b0;
        #1;
        chk_cyc("rm_async", 4'b0000, 0);
        chk("rm_async_busy", busy, 0);
        chk("rm_async_ready", req_ready, 0);
        chk("rm_async_wdata", wdata, 0);
        chk("rm_unsent", sb.size(), 2);
        sb.delete();
        step();
        rstn = 1'b1;
        clear_reqs();
        push_beat(0, 32'h50, 1'b1);
        push_beat(1, 32'h51, 1'b1);
        step(); settle(); chk_cyc("rm_idle", 4'b0000, 0);
        step(); settle(); chk_cyc("rm_g0", 4'b0001, 1);
        step(); settle(); chk_cyc("rm_bubble", 4'b0000, 0);
        step(); settle(); chk_cyc("rm_g1", 4'b0010, 1);
        step(); settle(); chk_cyc("rm_end", 4'b0000, 0);
        chk("rm_sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of the async FIFO among `N_REQ` requesters in the write-clock domain. It grants one requester at a time for a bounded burst and forwards that requester's beats as `write_en`/`wdata`. It stalls on `full` and releases on the requester's `last` beat, on burst-length exhaustion or when `valid` drops. It sits directly in front of the FIFO's write side, clocked by the FIFO write clock.

## Interface
- `N_REQ`, 4, number of requesters (≥2).
- `WIDTH`, 32, data width; matches FIFO `WIDTH`.
- `MAX_BURST`, 4, maximum beats per grant (≥1).

Ports:
- `clk`  in  1  write-domain clock (the FIFO write clock).
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester beat valid.
- `req_last`  in  N_REQ  per-requester end-of-packet marker, qualified by valid.
- `req_data`  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  N_REQ  beat accepted when valid & ready.
- `full`  in  1  FIFO full flag (write-domain synchronized).
- `write_en`  out  1  FIFO write strobe.
- `wdata`  out  WIDTH  FIFO write data.
- `grant`  out  N_REQ  one-hot current owner; all-zero when idle.
- `busy`  out  1  high while in BURST.

## Operation
- Two states: IDLE and BURST.
- Registered state: `state`, `grant`, the round-robin pointer `rr_ptr` ($clog2(N_REQ) bits) and `beat_cnt` ($clog2(MAX_BURST+1) bits).
- **IDLE**
  - If any `req_valid` is high, select the first valid index searching upward from `rr_ptr`, with modulo-N_REQ wrap.
  - Next edge: load a one-hot `grant`, clear `beat_cnt`, enter BURST.
  - No `req_ready` and no `write_en` are asserted in IDLE.
- **BURST** (owner g)
  - `req_ready[g] = !full`. All other `req_ready` bits are 0.
  - `write_en = req_valid[g] & !full`, combinational from registered state.
  - `wdata = req_data[g]`. It is all-zero when no grant is held.
  - A beat is `write_en` high. Each beat increments `beat_cnt`.
- **Release to IDLE** at the next edge on any of:
  - a beat with `req_last[g]=1`;
  - a beat that makes `beat_cnt == MAX_BURST`;
  - `req_valid[g]=0` while `full=0` (owner has nothing to send).
- On release: `grant` clears to 0 and `rr_ptr` becomes (g+1) mod N_REQ.
- **full in BURST**
  - `write_en` and `req_ready` are held low and `beat_cnt` holds.
  - No release occurs while full, regardless of `req_valid[g]`.
  - No timeout.
- The `req_last`/`req_data` of non-granted requesters are ignored.
- Requesters must hold valid/data stable until accepted. The arbiter does not check this.

## Timing
- Reset (async assert, any time including mid-burst):
  - Outputs immediately: `grant=0`, `busy=0`, `write_en=0`, `req_ready=0`, `wdata=0`.
  - Internal: `rr_ptr=0`, `beat_cnt=0`, state IDLE.
  - Reset deasserts synchronously to the first edge with no other special behaviour.
- Arbitration latency: `req_valid` seen high in IDLE at edge k gives `grant`/`busy` after edge k. The first beat is possible in cycle k+1.
- Throughput: one beat per cycle within a burst when not full.
- One mandatory IDLE bubble cycle between consecutive grants.
- Releasing beat: a last-beat or MAX_BURST beat is written in that cycle. `grant` drops after the same edge.
- Simultaneous `full` rise and beat: `full` is sampled in the same cycle. `full=1` means no beat in that cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0…. Worst-case wait is (N_REQ-1)*(MAX_BURST+1) non-full cycles.

## Test plan
- **Reset mid-burst:**
  - Stimulus: req0 granted with 2 of 4 beats sent, then `rstn` pulsed low asynchronously between edges.
  - Response: `write_en`, `grant` and `busy` drop before the next edge.
  - After release, `req_valid=4'b0011` grants req0 (`rr_ptr=0`).
- **Single packet:**
  - Stimulus: req2 valid with 3 beats 0xA0, 0xA1, 0xA2, `last` on the 3rd, full=0.
  - Response: `grant=4'b0100` one cycle after valid, then three consecutive `write_en` with matching `wdata`, then `grant=0` and `rr_ptr=3`.
- **Burst cap:**
  - Stimulus: req1 streams 10 beats with no `last`, MAX_BURST=4, others idle.
  - Response: groups of 4 writes separated by one IDLE cycle (grants at cycles 1, 6, 11). The final group is 2 beats, and then valid drops.
- **Round-robin:**
  - Stimulus: all four requesters continuously valid, each beat with `last`.
  - Response: grant order 0,1,2,3,0,1; every two cycles `grant` alternates with idle.
- **Backpressure:**
  - Stimulus: req3 burst where `full` is high for 5 cycles after the 1st beat.
  - Response: `write_en=0` and `req_ready[3]=0` during those cycles with `beat_cnt` held at 1 and no release. Beats resume the cycle after `full` falls, with the burst still totalling 4 beats.
- **Valid drop:**
  - Stimulus: req0 granted, sends 1 beat, then deasserts valid with full=0.
  - Response: release after that edge and `rr_ptr=1`. A pending req1 is granted one cycle later.
